// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries with flush; head reads as zero when empty.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [XLEN-1:0]          push_pc,
    input  logic [XLEN-1:0]          push_instr,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic [XLEN-1:0]          head_pc,
    output logic [XLEN-1:0]          head_instr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= '{pc: push_pc, instr: push_instr};
        end
    end

    assign count      = count_q;
    assign empty      = (count_q == '0);
    assign head_pc    = empty ? '0 : mem_q[rd_ptr_q].pc;
    assign head_instr = empty ? '0 : mem_q[rd_ptr_q].instr;

    a_no_overflow:  assert property (@(posedge clk) disable iff (rst)
                        !(push && !pop && !flush && count_q == CNT_W'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
                        !(pop && !flush && count_q == '0));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC generation, credit-limited memory requests, redirect drop tracking.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             credit_ok, grant, resp, keep, pop;

    // Buffered plus outstanding words may never exceed the FIFO size.
    assign credit_ok = (SUM_W'(fifo_count) + SUM_W'(inflight_q)) < SUM_W'(DEPTH);
    assign imem_req  = !rst && !redirect_valid && credit_ok;
    assign imem_addr = fetch_pc_q;
    assign grant     = imem_req && imem_gnt;
    assign resp      = imem_rvalid && (inflight_q != '0);
    assign keep      = resp && !redirect_valid && (drop_q == '0);
    assign if_valid  = !fifo_empty && !redirect_valid;
    assign pop       = if_valid && if_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        if (redirect_valid) begin
            // Everything still outstanding belongs to the old path.
            fetch_pc_d = align_word(redirect_pc);
            resp_pc_d  = align_word(redirect_pc);
            inflight_d = inflight_q - CNT_W'(resp);
            drop_d     = inflight_q - CNT_W'(resp);
        end else begin
            if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
            if (keep)  resp_pc_d  = resp_pc_q + 32'd4;
            if (resp && drop_q != '0) drop_d = drop_q - CNT_W'(1);
            inflight_d = inflight_q + CNT_W'(grant) - CNT_W'(resp);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (keep),
        .push_pc    (resp_pc_q),
        .push_instr (imem_rdata),
        .pop        (pop),
        .count      (fifo_count),
        .empty      (fifo_empty),
        .head_pc    (if_pc),
        .head_instr (if_instr)
    );

    a_inflight_bound: assert property (@(posedge clk) disable iff (rst)
                          inflight_q <= CNT_W'(DEPTH));
    a_drop_bound:     assert property (@(posedge clk) disable iff (rst)
                          drop_q <= inflight_q);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with an in-order variable-latency memory model.
module tb_instr_fetch_unit;
    import riscv_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid, if_ready;
    logic [31:0] if_instr, if_pc;

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_ready       (if_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } req_t;

    req_t         pend[$];
    fetch_entry_t expq[$];

    int total = 0;
    int bad   = 0;
    int cyc, epoch, grants, pops;
    int first_gnt_cyc, first_val_cyc, redir_cyc;
    logic [31:0] m_fetch_pc, last_pop_pc, first_pop_pc;
    bit have_last, arm_first;

    int ctl_ready_pct, ctl_gnt_pct, ctl_redir_pct, lat_min, lat_max;
    bit force_redir;
    logic [31:0] force_pc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000 ^ {a[15:0], 16'h0};
    endfunction

    // One clock cycle: drive at negedge, check at +1, then apply the model's edge effects.
    task automatic step();
        bit          redir, exp_req, exp_v, rdv;
        logic [31:0] rpc;
        req_t        r;
        @(negedge clk);
        redir = force_redir || (int'($urandom_range(99)) < ctl_redir_pct);
        rpc   = force_redir ? force_pc : $urandom;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if_ready = (int'($urandom_range(99)) < ctl_ready_pct);
        imem_gnt = (int'($urandom_range(99)) < ctl_gnt_pct);
        rdv = (pend.size() > 0) && (pend[0].due <= cyc);
        imem_rvalid = rdv;
        imem_rdata  = rdv ? instr_of(pend[0].addr) : $urandom;
        #1;
        exp_req = !redir && (expq.size() + pend.size() < int'(DEPTH));
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (imem_req) chk("imem_addr", imem_addr, m_fetch_pc);
        exp_v = !redir && (expq.size() > 0);
        chk("if_valid", 32'(if_valid), 32'(exp_v));
        if (expq.size() == 0) begin
            chk("if_pc_empty", if_pc, 32'h0);
            chk("if_instr_empty", if_instr, 32'h0);
        end
        if (if_valid && first_val_cyc < 0) first_val_cyc = cyc;
        if (if_valid && if_ready && expq.size() > 0) begin
            chk("if_pc", if_pc, expq[0].pc);
            chk("if_instr", if_instr, expq[0].instr);
            if (have_last) chk("pc_step", if_pc, last_pop_pc + 32'd4);
            if (arm_first) begin
                first_pop_pc = if_pc;
                arm_first    = 1'b0;
            end
            last_pop_pc = if_pc;
            have_last   = 1'b1;
            pops++;
            void'(expq.pop_front());
        end
        if (redir) begin
            epoch++;
            expq.delete();
            m_fetch_pc    = {rpc[31:2], 2'b00};
            have_last     = 1'b0;
            arm_first     = 1'b1;
            first_val_cyc = -1;
            redir_cyc     = cyc;
        end
        if (rdv) begin
            r = pend.pop_front();
            if (r.epoch == epoch) expq.push_back('{pc: r.addr, instr: instr_of(r.addr)});
        end
        if (imem_req && imem_gnt) begin
            pend.push_back('{addr: m_fetch_pc, due: cyc + int'($urandom_range(lat_max, lat_min)), epoch: epoch});
            m_fetch_pc = m_fetch_pc + 32'd4;
            grants++;
            if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asynchronous assert mid-cycle, synchronous release on a falling edge.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        redirect_valid = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_if_valid", 32'(if_valid), 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_imem_addr", imem_addr, RESET_PC);
        pend.delete();
        expq.delete();
        epoch++;
        m_fetch_pc    = RESET_PC;
        have_last     = 1'b0;
        arm_first     = 1'b1;
        first_gnt_cyc = -1;
        first_val_cyc = -1;
        grants        = 0;
        pops          = 0;
        force_redir   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic set_ctl(input int rdy, input int gnt, input int lmin, input int lmax);
        ctl_ready_pct = rdy;
        ctl_gnt_pct   = gnt;
        lat_min       = lmin;
        lat_max       = lmax;
    endtask

    initial begin
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        if_ready       = 1'b0;
        epoch          = 0;
        ctl_redir_pct  = 0;
        force_pc       = '0;

        // Streaming with 1-cycle memory and decode always ready.
        do_reset();
        set_ctl(100, 100, 1, 1);
        run(20);
        chk("t1_first_latency", 32'(first_val_cyc - first_gnt_cyc), 32'd2);
        chk("t1_pops", 32'(pops), 32'd18);
        chk("t1_first_pc", first_pop_pc, RESET_PC);

        // Decode stalled: credit caps grants at DEPTH, then drain in order.
        do_reset();
        set_ctl(0, 100, 1, 1);
        run(10);
        chk("t2_grants", 32'(grants), 32'(DEPTH));
        set_ctl(100, 0, 1, 1);
        run(8);
        chk("t2_pops", 32'(pops), 32'(DEPTH));
        chk("t2_last_pc", last_pop_pc, RESET_PC + 32'hC);

        // Two slow requests in flight, then redirect to a misaligned target.
        do_reset();
        set_ctl(0, 100, 3, 3);
        run(2);
        set_ctl(0, 0, 3, 3);
        force_redir = 1'b1;
        force_pc    = 32'h0000_0102;
        run(1);
        force_redir = 1'b0;
        set_ctl(100, 100, 1, 1);
        run(12);
        chk("t3_first_pc", first_pop_pc, 32'h0000_0100);
        chk("t3_no_early", 32'(first_val_cyc >= redir_cyc + 3), 32'd1);

        // Redirect while a response arrives and decode is popping.
        do_reset();
        set_ctl(100, 100, 1, 1);
        run(6);
        force_redir = 1'b1;
        force_pc    = 32'h0000_0200;
        run(1);
        force_redir = 1'b0;
        run(8);
        chk("t4_first_pc", first_pop_pc, 32'h0000_0200);

        // Random grants, latencies, stalls and occasional redirects.
        do_reset();
        set_ctl(60, 50, 1, 4);
        ctl_redir_pct = 2;
        run(600);
        ctl_redir_pct = 0;

        // Reset in the middle of traffic, then restart from RESET_PC.
        set_ctl(70, 70, 1, 3);
        run(7);
        do_reset();
        set_ctl(100, 100, 1, 2);
        run(12);
        chk("t6_restart_pc", first_pop_pc, RESET_PC);
        chk("t6_progress", 32'(pops > 4), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage sitting directly upstream of the datapath/controller pair. Holds the fetch PC, issues in-order word requests to an instruction memory with a request/grant handshake and variable read latency, and buffers returned instructions with their PCs in a small FIFO. Presents one instruction per cycle to decode with a valid/ready handshake. Accepts a redirect (branch/jump target) that flushes buffered and in-flight instructions.

## Interface
Parameters:
- DEPTH, 4: FIFO entries and maximum in-flight credit; power of two, 2..16.
- RESET_PC, 32'h0000_0000: fetch PC after reset; bits [1:0] must be 0.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- imem_req  output  1  request valid.
- imem_addr  output  32  word-aligned fetch address.
- imem_gnt  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  response valid; responses return in request order, ≥1 cycle after grant.
- imem_rdata  input  32  instruction word.
- redirect_valid  input  1  restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch PC; bits [1:0] ignored, treated as 0.
- if_valid  output  1  instruction available to decode.
- if_instr  output  32  instruction.
- if_pc  output  32  PC of if_instr.
- if_ready  input  1  decode consumes the instruction this cycle.

## Operation
- State: fetch_pc (next request address), resp_pc (PC of next kept response), FIFO of {pc, instr}, inflight counter (0..DEPTH), drop counter (0..DEPTH).
- imem_req = !redirect_valid && (fifo_count + inflight < DEPTH). imem_addr = fetch_pc.
- Grant (imem_req && imem_gnt): fetch_pc += 4 (32-bit wrap), inflight += 1.
- Response with drop == 0: push {resp_pc, imem_rdata}, resp_pc += 4, inflight -= 1. Credit guarantees no overflow.
- Response with drop > 0: discard, drop -= 1, inflight -= 1.
- Pop on if_valid && if_ready. if_valid = FIFO non-empty && !redirect_valid. if_instr and if_pc come from the FIFO head.
- Redirect: FIFO emptied; fetch_pc and resp_pc ← {redirect_pc[31:2], 2'b00}; drop ← inflight minus any response arriving that cycle (that response is discarded); inflight unchanged apart from that decrement. No grant occurs in a redirect cycle.
- Back-to-back redirects: the last one wins; drop accumulates correctly.
- Counters never wrap. Any assertion showing inflight > DEPTH or FIFO overflow/underflow is a bug.

## Timing
- Reset (async assert, sync-clean deassert): fetch_pc = resp_pc = RESET_PC, FIFO empty, inflight = drop = 0. Outputs: imem_req = 1 after reset releases (0 during reset), imem_addr = RESET_PC, if_valid = 0, if_instr = 0, if_pc = 0 while empty.
- Reset mid-operation: all state cleared immediately. Responses for earlier grants that arrive after reset are the memory's responsibility; the memory is reset by the same rst.
- Latency: grant at cycle t with rvalid at t+1 gives if_valid at t+2 (FIFO write, then registered head).
- Throughput: with 1-cycle memory latency and if_ready held high, one instruction per cycle sustained.
- Redirect at cycle t: imem_req with the new address at t+1; first new instruction visible no earlier than t+3.
- Full FIFO with if_ready low: imem_req stays low until a pop frees credit.

## Structure
- A shared package (riscv_pkg) holds the fetch_entry_t struct {pc, instr}, the XLEN = 32 constant, and the NOP encoding 32'h0000_0013 for downstream use.
- One sub-module, fetch_fifo: synchronous FIFO parametrised on DEPTH, with flush, push, pop, count and head outputs. The top level holds PC logic, credit logic and drop logic.

## Test plan
- Reset then if_ready=1, gnt=1, 1-cycle latency: instructions at PCs 0x0, 0x4, 0x8 … appear on consecutive cycles starting at cycle 3 after reset release.
- if_ready=0 for 10 cycles: exactly DEPTH grants issued, then imem_req=0; raise if_ready → PCs 0x0..0xC in order, with no loss or duplication.
- 3-cycle latency with 2 requests in flight, redirect to 0x100 (pc 0x102 must also give 0x100): both old responses dropped; first if_pc = 0x100.
- Redirect in the same cycle as a response and a pop: response discarded, FIFO empty next cycle, if_valid low during the redirect cycle.
- imem_gnt toggling randomly and latency 1–4: if_pc sequence strictly +4, inflight ≤ DEPTH throughout.
- rst asserted mid-stream: outputs return to reset values asynchronously; after release, fetch restarts at RESET_PC.
